// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage datapath. Stage 1 reads the register file (with
// operand bypass and stage-2 forwarding) and latches the micro-instruction.
// Stage 2 runs the ALU and commits the register file, flags and output register.
module datapath_pipe #(
  parameter int M = 3,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic [M-1:0] waddr,
  input  logic [M-1:0] ra,
  input  logic [M-1:0] rb,
  input  logic [2:0]   op,
  input  logic         ie,
  input  logic         write,
  input  logic         reada,
  input  logic         readb,
  input  logic         en,
  input  logic         oe,
  input  logic [N-1:0] offset,
  input  logic         bypassa,
  input  logic         bypassb,
  output logic [N-1:0] dout,
  output logic         o_flag,
  output logic         z_flag,
  output logic         n_flag,
  output logic         c_flag,
  output logic         valid
);

  localparam int unsigned DEPTH = 1 << M;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_MOV = 3'b110,
    OP_INC = 3'b111
  } alu_op_e;

  logic [N-1:0] rf [DEPTH];

  // Stage-2 pipeline registers
  logic [N-1:0] a_s, b_s, din_s;
  alu_op_e      op_s;
  logic         ie_s, write_s, en_s, oe_s;
  logic [M-1:0] waddr_s;

  // Stage-2 combinational results
  logic [N-1:0] r, wb, y;
  logic [N:0]   sum;
  logic         cin, arith, carry, ovf;

  // Stage-1 operands
  logic [N-1:0] rf_a, rf_b, op_a, op_b;

  // ALU: arithmetic ops share one adder (SUB = A + ~B + 1, INC = A + 0 + 1)
  always_comb begin
    y     = '0;
    cin   = 1'b0;
    arith = 1'b0;
    r     = '0;
    sum   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    unique case (op_s)
      OP_ADD: begin y = b_s;  arith = 1'b1; end
      OP_SUB: begin y = ~b_s; cin = 1'b1; arith = 1'b1; end
      OP_INC: begin y = '0;   cin = 1'b1; arith = 1'b1; end
      OP_AND: r = a_s & b_s;
      OP_OR:  r = a_s | b_s;
      OP_XOR: r = a_s ^ b_s;
      OP_NOT: r = ~a_s;
      OP_MOV: r = a_s;
      default: r = '0;
    endcase
    if (arith) begin
      sum   = {1'b0, a_s} + {1'b0, y} + {{N{1'b0}}, cin};
      r     = sum[N-1:0];
      carry = sum[N];
      // Overflow on the effective second operand y, so SUB and INC need no special case
      ovf   = (a_s[N-1] == y[N-1]) && (r[N-1] != a_s[N-1]);
    end
  end

  // Write-back data selection
  always_comb begin
    wb = ie_s ? din_s : r;
  end

  // Stage-1 operand fetch: forwarding from stage 2, then gating, then bypass
  always_comb begin
    rf_a = (write_s && (waddr_s == ra)) ? wb : rf[ra];
    rf_b = (write_s && (waddr_s == rb)) ? wb : rf[rb];
    op_a = bypassa ? offset : (reada ? rf_a : '0);
    op_b = bypassb ? offset : (readb ? rf_b : '0);
  end

  // Stage-1 to stage-2 pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_s     <= '0;
      b_s     <= '0;
      din_s   <= '0;
      op_s    <= OP_ADD;
      ie_s    <= 1'b0;
      write_s <= 1'b0;
      en_s    <= 1'b0;
      oe_s    <= 1'b0;
      waddr_s <= '0;
    end else begin
      a_s     <= op_a;
      b_s     <= op_b;
      din_s   <= din;
      op_s    <= alu_op_e'(op);
      ie_s    <= ie;
      write_s <= write;
      en_s    <= en;
      oe_s    <= oe;
      waddr_s <= waddr;
    end
  end

  // Register file write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (write_s) begin
      rf[waddr_s] <= wb;
    end
  end

  // Flag register, updated from the ALU result even when din is written back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_flag <= 1'b0;
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      c_flag <= 1'b0;
    end else if (en_s) begin
      o_flag <= ovf;
      z_flag <= (r == '0);
      n_flag <= r[N-1];
      c_flag <= carry;
    end
  end

  // Output register and its load strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= oe_s;
      if (oe_s) dout <= wb;
    end
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Scoreboard bench for datapath_pipe: directed micro-instructions push their
// hand-computed dout/flags; a negedge monitor pops whenever valid is high.
module tb_datapath_pipe;

  localparam int M = 3;
  localparam int N = 8;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, MOV = 3'b110,
                         NOT_ = 3'b101, INC = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] din, offset, dout;
  logic [M-1:0] waddr, ra, rb;
  logic [2:0]   op;
  logic         ie, write, reada, readb, en, oe, bypassa, bypassb;
  logic         o_flag, z_flag, n_flag, c_flag, valid;

  typedef struct {
    logic [N-1:0] d;
    logic [3:0]   f;   // {O,Z,N,C}
    bit           cf;  // compare flags too
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_push = 0;
  int   n_valid = 0;

  datapath_pipe #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .din(din), .waddr(waddr), .ra(ra), .rb(rb), .op(op),
    .ie(ie), .write(write), .reada(reada), .readb(readb), .en(en), .oe(oe),
    .offset(offset), .bypassa(bypassa), .bypassb(bypassb), .dout(dout),
    .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag), .c_flag(c_flag), .valid(valid)
  );

  always #5 clk = ~clk;

  // Monitor: consume one expectation per valid pulse
  always @(negedge clk) begin
    if (rst && valid) begin
      exp_t e;
      n_valid++;
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_valid: dout=%h with empty scoreboard", dout);
      end else begin
        e = sb.pop_front();
        if (dout !== e.d) begin
          n_miss++;
          $display("FAIL dout: got %h expected %h", dout, e.d);
        end
        if (e.cf) begin
          n_vec++;
          if ({o_flag, z_flag, n_flag, c_flag} !== e.f) begin
            n_miss++;
            $display("FAIL flags(OZNC): got %b expected %b",
                     {o_flag, z_flag, n_flag, c_flag}, e.f);
          end
        end
      end
    end
  end

  task automatic nop();
    din = '0; offset = '0; waddr = '0; ra = '0; rb = '0; op = ADD;
    ie = 0; write = 0; reada = 0; readb = 0; en = 0; oe = 0; bypassa = 0; bypassb = 0;
  endtask

  task automatic expect_out(input logic [N-1:0] d, input logic [3:0] f, input bit cf);
    exp_t e;
    e.d = d; e.f = f; e.cf = cf;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic issue(input logic [2:0] op_i, input logic [M-1:0] ra_i, rb_i, wa_i,
                       input bit wr_i, ie_i, en_i, oe_i, rda_i, rdb_i, bpa_i, bpb_i,
                       input logic [N-1:0] din_i, off_i);
    op = op_i; ra = ra_i; rb = rb_i; waddr = wa_i; write = wr_i; ie = ie_i;
    en = en_i; oe = oe_i; reada = rda_i; readb = rdb_i; bypassa = bpa_i;
    bypassb = bpb_i; din = din_i; offset = off_i;
    @(posedge clk); #1;
    nop();
  endtask

  task automatic ld(input logic [M-1:0] a, input logic [N-1:0] v);
    issue(MOV, 0, 0, a, 1, 1, 0, 0, 0, 0, 0, 0, v, 0);
  endtask

  // op on ra/rb, optional write to wa, en/oe
  task automatic alu(input logic [2:0] o, input logic [M-1:0] a, b, wa,
                     input bit wr_i, en_i, oe_i);
    issue(o, a, b, wa, wr_i, 0, en_i, oe_i, 1, 1, 0, 0, 0, 0);
  endtask

  task automatic chk_idle(input string name);
    n_vec++;
    if (dout !== '0 || valid !== 1'b0 || {o_flag, z_flag, n_flag, c_flag} !== 4'b0000) begin
      n_miss++;
      $display("FAIL %s: dout=%h valid=%b flags=%b expected 00/0/0000", name, dout, valid,
               {o_flag, z_flag, n_flag, c_flag});
    end
  endtask

  initial begin
    nop();
    rst = 1'b0;
    #8 chk_idle("power_on_reset");
    #4 rst = 1'b1;
    @(posedge clk); #1;

    // Reset while an instruction is in flight and outputs are non-zero
    ld(0, 8'h55);
    expect_out(8'hAA, 4'b0010, 1);
    alu(NOT_, 0, 0, 0, 0, 1, 1);           // ~0x55 = 0xAA, N=1
    ld(1, 8'h77);                          // in stage 2 when reset hits
    @(negedge clk); #1;
    rst = 1'b0;
    #1 chk_idle("async_reset");
    #2 rst = 1'b1;
    expect_out(8'h00, 4'b0000, 1);
    alu(MOV, 0, 0, 0, 0, 0, 1);            // r0 cleared
    expect_out(8'h00, 4'b0000, 1);
    alu(MOV, 1, 0, 0, 0, 0, 1);            // in-flight r1 write discarded

    // Load and add, with distance-1 forwarding into ADD and MOV
    ld(0, 8'h02);
    ld(1, 8'h03);
    alu(ADD, 0, 1, 3, 1, 1, 0);
    expect_out(8'h05, 4'b0000, 1);
    alu(MOV, 3, 0, 0, 0, 0, 1);

    // Back-to-back dependent ADDs
    alu(ADD, 0, 1, 2, 1, 0, 0);
    expect_out(8'h0A, 4'b0000, 1);
    alu(ADD, 2, 2, 4, 1, 1, 1);

    // Wrap-around on INC
    ld(0, 8'hFF);
    expect_out(8'h00, 4'b0101, 1);
    alu(INC, 0, 0, 0, 0, 1, 1);
    ld(0, 8'h7F);
    expect_out(8'h80, 4'b1010, 1);
    alu(INC, 0, 0, 0, 0, 1, 1);

    // Subtract with borrow, then flags hold across en=0
    ld(0, 8'h02);
    expect_out(8'hFF, 4'b0010, 1);
    alu(SUB, 0, 1, 0, 0, 1, 1);
    expect_out(8'h02, 4'b0010, 1);
    alu(AND_, 0, 1, 0, 0, 0, 1);

    // Bypass and read gating (r1=3, flags still held)
    expect_out(8'h13, 4'b0010, 1);
    issue(ADD, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 8'h10);
    expect_out(8'h10, 4'b0010, 1);
    issue(ADD, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 8'h10);
    expect_out(8'h20, 4'b0010, 1);
    issue(ADD, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 8'h10);

    // ie=1: dout takes din, flags still from ALU (2-2 = 0, carry set)
    expect_out(8'h99, 4'b0101, 1);
    issue(SUB, 0, 0, 5, 1, 1, 1, 1, 1, 1, 0, 0, 8'h99, 0);
    expect_out(8'h99, 4'b0101, 1);
    alu(MOV, 5, 0, 0, 0, 0, 1);            // forwarded din write-back

    // ie/din with no write and no oe is invisible
    issue(MOV, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'hEE, 0);
    expect_out(8'h02, 4'b0101, 1);
    alu(MOV, 0, 0, 0, 0, 0, 1);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    n_vec++;
    if (n_valid != n_push) begin
      n_miss++;
      $display("FAIL valid_count: got %0d pulses expected %0d", n_valid, n_push);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised two-stage successor of the single-cycle datapath. It holds a 2^M × N register file with two read ports and operand bypass from `offset`. The ALU, flag register and output register sit in a second pipeline stage. Same-address results from stage 2 are forwarded to stage 1, so back-to-back dependent micro-instructions run without stalls. The block sits between the microcode sequencer (control inputs) and the external data bus (`din`/`dout`).

## Interface
- `M`, 3, register address width (2^M registers)
- `N`, 8, data width (N ≥ 2)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `din`  in  N  external input data
- `waddr`  in  M  write-back register address
- `ra`, `rb`  in  M  read addresses, operands A/B
- `op`  in  3  ALU operation
- `ie`  in  1  write-back selects `din` instead of ALU result
- `write`  in  1  register-file write enable
- `reada`, `readb`  in  1  read enables; 0 forces that operand to 0
- `en`  in  1  flag update enable
- `oe`  in  1  output register load enable
- `offset`  in  N  immediate operand
- `bypassa`, `bypassb`  in  1  operand A/B taken from `offset`
- `dout`  out  N  registered output data
- `o_flag`, `z_flag`, `n_flag`, `c_flag`  out  1  overflow, zero, negative, carry
- `valid`  out  1  one-cycle pulse when `dout` was loaded

## Operation
- Stage 1 (issue, cycle t):
  - A = bypassa ? offset : (reada ? RFfwd[ra] : 0).
  - B = bypassb ? offset : (readb ? RFfwd[rb] : 0).
  - A, B, op, ie, din, write, waddr, en and oe are latched at the edge ending t.
- RFfwd[x]: if stage 2 has write_s=1 and waddr_s==x, the value is stage-2 write-back data. Otherwise it is RF[x]. Bypass takes priority over forwarding.
- Stage 2 (cycle t+1):
  - R = ALU(A,B).
  - wb = ie_s ? din_s : R.
  - At the edge ending t+1: if write_s, RF[waddr_s] ← wb. If en_s, flags ← flags(R). If oe_s, dout ← wb and valid ← 1; otherwise valid ← 0.
- ALU ops, all modulo 2^N:
  - 000 ADD A+B, 001 SUB A−B (A+~B+1), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 MOV A, 111 INC A+1.
- Flags computed on R even when ie_s=1:
  - Z = (R==0).
  - N = R[N-1].
  - C = carry out of bit N-1 for ADD/SUB/INC (SUB: C=1 means no borrow); 0 for logic ops.
  - O = signed overflow for ADD/SUB/INC; 0 otherwise.
- With en_s=0, flags hold.
- No register is hardwired. Writes to every address are legal.

## Timing
- Reset (rst=0, asynchronous) clears everything immediately, independent of `clk`:
  - All RF entries 0.
  - All stage-2 registers 0, including write_s, en_s and oe_s.
  - dout=0, valid=0, all flags 0.
- An instruction in flight at reset is discarded. No write occurs on the first edge after release.
- Latency: an instruction issued in cycle t updates RF, flags and dout at the edge ending t+1. Outputs are visible in t+2.
- Throughput: one instruction per cycle. No stalls, no handshake back to the sequencer.
- Forwarding distance is exactly 1. At distance ≥2 the value is already in RF.
- Simultaneous stage-2 write and stage-1 read of the same address returns wb, never the stale RF value.
- Two stage-2 consumers of the same address: the newest write wins by program order, because only one write per edge occurs.
- `din`/`ie` with write=0 and oe=0 has no visible effect.

## Test plan
- Reset: load r0=0x55, assert rst=0 between edges → dout=0, all flags 0, valid=0 at once. After release, MOV r0 with oe=1 → dout=0x00.
- Load and add: ie=1 write r0=0x02, then r1=0x03. Then ADD ra=0,rb=1 write r3, en=1. Then MOV ra=3 with oe=1 → dout=0x05, Z=N=C=O=0, valid pulses once.
- Forwarding: ADD r0,r1→r2 issued, immediately followed by ADD r2,r2→r4 with oe=1 → dout=0x0A. Without forwarding it would wrongly read 0x00/0x0A mix.
- Wrap-around:
  - r0=0xFF, INC r0 en=1 → R=0x00, Z=1, C=1, O=0.
  - r0=0x7F, INC → 0x80, N=1, O=1, C=0.
- Subtract and flag hold: r0=2, r1=3, SUB en=1 → 0xFF, N=1, C=0, O=0. Next op AND with en=0 → flags unchanged.
- Bypass and read gating: bypassb=1, offset=0x10, ADD ra=1 (r1=3) → 0x13. Same op with reada=0 → 0x10. With bypassa=1 and reada=0 → A=offset, giving 0x20.
